aes_key_expand_seq: RTL and testbench

Sequential AES key-schedule engine that expands one cipher key into the full round-key set for AES-128, AES-192 or AES-256. It is selected by the same 2-bit `mode` encoding used by the existing round-key logic. A parametrised number of S-box lanes trades area against latency. The expanded words are held in an internal word store and served through a random-access round-key read port to the cipher/decipher datapaths, which need keys in forward or reverse order.

---
 rtl/aes_pkg.sv | 46 ++++
 rtl/aes_sbox.sv | 31 +++
 rtl/aes_key_expand_seq.sv | 245 ++++++++++++++++++++++++
 tb/tb_aes_key_expand_seq.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions for the key-schedule and round-key logic.
//   aes_mode_e   : 2-bit key-size selector (00 AES-128, 01 AES-192, 10 AES-256)
//   ks_state_e   : key-expansion FSM states
//   GF_REDUCE    : GF(2^8) reduction constant used by xtime
//   MAX_WORDS    : depth of the expanded-key word store (AES-256 size)
//   nk_of/nr_of  : key length in words / number of rounds for a mode
//   xtime        : multiply-by-two in GF(2^8), used to step Rcon
package aes_pkg;

    typedef enum logic [1:0] {
        MODE_AES128 = 2'b00,
        MODE_AES192 = 2'b01,
        MODE_AES256 = 2'b10
    } aes_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_XOR,
        ST_SUB,
        ST_DONE
    } ks_state_e;

    localparam logic [7:0] GF_REDUCE = 8'h1b;
    localparam int         MAX_WORDS = 60;

    function automatic logic [3:0] nk_of(input aes_mode_e m);
        case (m)
            MODE_AES128: return 4'd4;
            MODE_AES192: return 4'd6;
            default:     return 4'd8;
        endcase
    endfunction

    function automatic logic [3:0] nr_of(input aes_mode_e m);
        case (m)
            MODE_AES128: return 4'd10;
            MODE_AES192: return 4'd12;
            default:     return 4'd14;
        endcase
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? GF_REDUCE : 8'h00);
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box, purely combinational table lookup.
//   in_byte  : byte to substitute
//   out_byte : SubBytes(in_byte)
module aes_sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    // Entry 0x00 sits in the top byte, so the slice offset is 8 * (255 - x) = {~x, 3'b000}.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign out_byte = SBOX_TABLE[{~in_byte, 3'b000} +: 8];

endmodule

// File: rtl/aes_key_expand_seq.sv
// Sequential AES key-schedule engine for AES-128/192/256.
// Expands the cipher key one word at a time into a 60-word store and serves
// whole round keys through a combinational random-access read port.
//   clk, reset_n  : clock, synchronous active-low reset
//   start, mode   : expansion request and key size (sampled in IDLE)
//   key_in        : MSB-aligned cipher key, w0 = key_in[255:224]
//   busy          : expansion in progress
//   done, err     : one-cycle pulses for completion / illegal-mode start
//   key_valid     : round keys readable
//   rk_addr       : round index 0..Nr
//   rk_data       : {w[4r], w[4r+1], w[4r+2], w[4r+3]}, zero when invalid
module aes_key_expand_seq
    import aes_pkg::*;
#(
    parameter int SBOX_LANES = 1
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           start,
    input  logic [1:0]     mode,
    input  logic [255:0]   key_in,
    output logic           busy,
    output logic           done,
    output logic           err,
    output logic           key_valid,
    input  logic [3:0]     rk_addr,
    output logic [127:0]   rk_data
);

    // SBOX_LANES must divide 4; each SUB word takes this many cycles.
    localparam int         SUB_CYCLES = 4 / SBOX_LANES;
    localparam logic [1:0] SUB_LAST   = 2'(SUB_CYCLES - 1);

    ks_state_e   state_q, state_d;
    aes_mode_e   mode_q, mode_d;
    logic [5:0]  i_q, i_d;
    logic [2:0]  pos_q, pos_d;
    logic [7:0]  rcon_q, rcon_d;
    logic [31:0] t_q, t_d;
    logic [1:0]  sub_cnt_q, sub_cnt_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        key_valid_q, key_valid_d;
    logic [31:0] w_q [MAX_WORDS];
    logic [31:0] w_d [MAX_WORDS];

    aes_mode_e   mode_in;
    logic [3:0]  nk_in;
    logic [3:0]  nk;
    logic [3:0]  nr;
    logic [5:0]  i_prev;
    logic [5:0]  i_back;
    logic [5:0]  last_word;
    logic        rot_now;
    logic        plain_now;
    logic [31:0] prev_word;
    logic [31:0] sub_src;
    logic [31:0] t_sub;
    logic [31:0] mix;
    logic [2:0]  pos_next;
    logic        next_sub;
    logic [7:0]  sbox_in  [SBOX_LANES];
    logic [7:0]  sbox_out [SBOX_LANES];

    // Bit offset of the byte handled by a lane in a given SUB cycle; byte 0 is the MSB.
    function automatic int lane_lsb(input logic [1:0] cnt, input int lane);
        return 8 * (3 - (int'(cnt) * SBOX_LANES + lane));
    endfunction

    assign mode_in   = aes_mode_e'(mode);
    assign nk_in     = nk_of(mode_in);
    assign nk        = nk_of(mode_q);
    assign nr        = nr_of(mode_q);
    assign i_prev    = i_q - 6'd1;
    assign i_back    = i_q - {2'b00, nk};
    assign last_word = {nr, 2'b11};
    // pos_q tracks i mod Nk so no divider is needed for the substitution test.
    assign rot_now   = (pos_q == 3'd0);
    assign plain_now = (nk == 4'd8) && (pos_q == 3'd4);

    // The first SUB cycle reads w[i-1] straight from the store (rotated for
    // RotWord words); later cycles keep working on the partly substituted temp.
    always_comb begin
        prev_word = w_q[i_prev];
        if (sub_cnt_q == 2'd0) begin
            sub_src = rot_now ? {prev_word[23:0], prev_word[31:24]} : prev_word;
        end else begin
            sub_src = t_q;
        end
    end

    always_comb begin
        for (int l = 0; l < SBOX_LANES; l++) begin
            sbox_in[l] = sub_src[lane_lsb(sub_cnt_q, l) +: 8];
        end
    end

    for (genvar g = 0; g < SBOX_LANES; g++) begin : g_sbox
        aes_sbox u_sbox (
            .in_byte  (sbox_in[g]),
            .out_byte (sbox_out[g])
        );
    end

    always_comb begin
        t_sub = sub_src;
        for (int l = 0; l < SBOX_LANES; l++) begin
            t_sub[lane_lsb(sub_cnt_q, l) +: 8] = sbox_out[l];
        end
    end

    // Next-state logic for the FSM, datapath registers and word store.
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        i_d         = i_q;
        pos_d       = pos_q;
        rcon_d      = rcon_q;
        t_d         = t_q;
        sub_cnt_d   = sub_cnt_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        key_valid_d = key_valid_q;
        w_d         = w_q;
        mix         = 32'h0;
        pos_next    = ({1'b0, pos_q} == nk - 4'd1) ? 3'd0 : pos_q + 3'd1;
        next_sub    = (pos_next == 3'd0) || ((nk == 4'd8) && (pos_next == 3'd4));

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (mode == 2'b11) begin
                        err_d = 1'b1;
                    end else begin
                        mode_d = mode_in;
                        for (int k = 0; k < 8; k++) begin
                            if (k < int'(nk_in)) begin
                                w_d[k] = key_in[255 - 32 * k -: 32];
                            end
                        end
                        i_d         = {2'b00, nk_in};
                        pos_d       = 3'd0;
                        rcon_d      = 8'h01;
                        sub_cnt_d   = 2'd0;
                        busy_d      = 1'b1;
                        key_valid_d = 1'b0;
                        // w[Nk] is always a RotWord word.
                        state_d     = ST_SUB;
                    end
                end
            end

            ST_SUB: begin
                t_d = t_sub;
                if (sub_cnt_q == SUB_LAST) begin
                    sub_cnt_d = 2'd0;
                    state_d   = ST_XOR;
                end else begin
                    sub_cnt_d = sub_cnt_q + 2'd1;
                end
            end

            ST_XOR: begin
                if (rot_now) begin
                    mix    = t_q ^ {rcon_q, 24'h0};
                    rcon_d = xtime(rcon_q);
                end else if (plain_now) begin
                    mix = t_q;
                end else begin
                    mix = w_q[i_prev];
                end
                w_d[i_q] = w_q[i_back] ^ mix;
                if (i_q == last_word) begin
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                    key_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end else begin
                    i_d     = i_q + 6'd1;
                    pos_d   = pos_next;
                    state_d = next_sub ? ST_SUB : ST_XOR;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control and datapath registers; reset aborts any expansion in flight.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            mode_q      <= MODE_AES128;
            i_q         <= 6'd0;
            pos_q       <= 3'd0;
            rcon_q      <= 8'h01;
            t_q         <= 32'h0;
            sub_cnt_q   <= 2'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            key_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            i_q         <= i_d;
            pos_q       <= pos_d;
            rcon_q      <= rcon_d;
            t_q         <= t_d;
            sub_cnt_q   <= sub_cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            key_valid_q <= key_valid_d;
        end
    end

    // The word store is never reset; key_valid masking hides stale contents.
    always_ff @(posedge clk) begin
        w_q <= w_d;
    end

    always_comb begin
        if (key_valid_q && (rk_addr <= nr)) begin
            rk_data = {w_q[{rk_addr, 2'b00}], w_q[{rk_addr, 2'b01}],
                       w_q[{rk_addr, 2'b10}], w_q[{rk_addr, 2'b11}]};
        end else begin
            rk_data = 128'h0;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign key_valid = key_valid_q;

endmodule

// File: tb/tb_aes_key_expand_seq.sv
// Testbench for aes_key_expand_seq: three instances (1, 2 and 4 S-box lanes)
// share all inputs; FIPS-197 key-expansion vectors are checked for each key
// size along with done latency, read-port masking, illegal mode, start while
// busy and reset abort/restart.
module tb_aes_key_expand_seq;

    localparam logic [255:0] KEY128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] KEY192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] KEY256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    localparam logic [127:0] RK128_0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] RK128_1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] RK128_10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] RK192_12 = 128'he98ba06f448c773c8ecc720401002202;
    localparam logic [127:0] RK256_1  = 128'h1f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] RK256_2  = 128'h9ba354118e6925afa51a8b5f2067fcde;
    localparam logic [127:0] RK256_14 = 128'hfe4890d1e6188d0b046df344706c631e;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start;
    logic [1:0]   mode;
    logic [255:0] key_in;
    logic [3:0]   rk_addr;

    logic         busy1, done1, err1, kv1;
    logic         busy2, done2, err2, kv2;
    logic         busy4, done4, err4, kv4;
    logic [127:0] rk1, rk2, rk4;

    int nchecks = 0;
    int nfails  = 0;

    always #5 clk = ~clk;

    aes_key_expand_seq #(.SBOX_LANES(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .start(start), .mode(mode), .key_in(key_in),
        .busy(busy1), .done(done1), .err(err1), .key_valid(kv1),
        .rk_addr(rk_addr), .rk_data(rk1)
    );

    aes_key_expand_seq #(.SBOX_LANES(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .start(start), .mode(mode), .key_in(key_in),
        .busy(busy2), .done(done2), .err(err2), .key_valid(kv2),
        .rk_addr(rk_addr), .rk_data(rk2)
    );

    aes_key_expand_seq #(.SBOX_LANES(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .start(start), .mode(mode), .key_in(key_in),
        .busy(busy4), .done(done4), .err(err4), .key_valid(kv4),
        .rk_addr(rk_addr), .rk_data(rk4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Holds start for one edge; returns in cycle 1 of the run.
    task automatic start_run(input logic [1:0] m, input logic [255:0] k);
        mode   = m;
        key_in = k;
        start  = 1'b1;
        tick();
        start  = 1'b0;
    endtask

    // Records the cycle in which each instance first shows done (0 = never).
    task automatic wait_all(input int cyc0, input int max_cyc, output int c1, output int c2, output int c4);
        int cyc;
        cyc = cyc0;
        c1 = 0;
        c2 = 0;
        c4 = 0;
        forever begin
            if (done1 && c1 == 0) c1 = cyc;
            if (done2 && c2 == 0) c2 = cyc;
            if (done4 && c4 == 0) c4 = cyc;
            if ((c1 != 0 && c2 != 0 && c4 != 0) || cyc >= max_cyc) break;
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        start   = 1'b0;
        mode    = 2'b00;
        key_in  = '0;
        rk_addr = 4'd0;
        tick();
        tick();
        nchecks++; if (busy1 !== 1'b0) begin nfails++; $display("[TB] FAIL reset_busy: got %b expected 0", busy1); end
        nchecks++; if (done1 !== 1'b0) begin nfails++; $display("[TB] FAIL reset_done: got %b expected 0", done1); end
        nchecks++; if (err1 !== 1'b0) begin nfails++; $display("[TB] FAIL reset_err: got %b expected 0", err1); end
        nchecks++; if (kv1 !== 1'b0) begin nfails++; $display("[TB] FAIL reset_key_valid: got %b expected 0", kv1); end
        nchecks++; if (rk1 !== 128'h0) begin nfails++; $display("[TB] FAIL reset_rk_data: got %h expected 0", rk1); end
        reset_n = 1'b1;
        tick();
        nchecks++; if (kv4 !== 1'b0 || busy4 !== 1'b0) begin nfails++; $display("[TB] FAIL reset_lane4_idle: got kv=%b busy=%b expected 0 0", kv4, busy4); end
    endtask

    task automatic test_aes128();
        int c1, c2, c4;
        start_run(2'b00, KEY128);
        nchecks++; if (busy1 !== 1'b1) begin nfails++; $display("[TB] FAIL aes128_busy: got %b expected 1", busy1); end
        wait_all(1, 200, c1, c2, c4);
        nchecks++; if (c1 !== 81) begin nfails++; $display("[TB] FAIL aes128_done_l1: got %0d expected 81", c1); end
        nchecks++; if (c2 !== 61) begin nfails++; $display("[TB] FAIL aes128_done_l2: got %0d expected 61", c2); end
        nchecks++; if (c4 !== 51) begin nfails++; $display("[TB] FAIL aes128_done_l4: got %0d expected 51", c4); end
        nchecks++; if (kv1 !== 1'b1) begin nfails++; $display("[TB] FAIL aes128_key_valid: got %b expected 1", kv1); end
        rk_addr = 4'd10; #1;
        nchecks++; if (rk1 !== RK128_10) begin nfails++; $display("[TB] FAIL aes128_rk10_l1: got %h expected %h", rk1, RK128_10); end
        nchecks++; if (rk2 !== RK128_10) begin nfails++; $display("[TB] FAIL aes128_rk10_l2: got %h expected %h", rk2, RK128_10); end
        nchecks++; if (rk4 !== RK128_10) begin nfails++; $display("[TB] FAIL aes128_rk10_l4: got %h expected %h", rk4, RK128_10); end
        rk_addr = 4'd0; #1;
        nchecks++; if (rk1 !== RK128_0) begin nfails++; $display("[TB] FAIL aes128_rk0: got %h expected %h", rk1, RK128_0); end
        rk_addr = 4'd1; #1;
        nchecks++; if (rk1 !== RK128_1) begin nfails++; $display("[TB] FAIL aes128_rk1: got %h expected %h", rk1, RK128_1); end
        rk_addr = 4'd11; #1;
        nchecks++; if (rk1 !== 128'h0) begin nfails++; $display("[TB] FAIL aes128_rk11_zero: got %h expected 0", rk1); end
        rk_addr = 4'd15; #1;
        nchecks++; if (rk1 !== 128'h0) begin nfails++; $display("[TB] FAIL aes128_rk15_zero: got %h expected 0", rk1); end
        tick();
        nchecks++; if (done1 !== 1'b0) begin nfails++; $display("[TB] FAIL aes128_done_pulse: got %b expected 0", done1); end
        nchecks++; if (kv1 !== 1'b1) begin nfails++; $display("[TB] FAIL aes128_key_valid_hold: got %b expected 1", kv1); end
    endtask

    task automatic test_illegal_mode();
        rk_addr = 4'd10;
        start_run(2'b11, KEY256);
        nchecks++; if (err1 !== 1'b1) begin nfails++; $display("[TB] FAIL illegal_err: got %b expected 1", err1); end
        nchecks++; if (kv1 !== 1'b1) begin nfails++; $display("[TB] FAIL illegal_key_valid: got %b expected 1", kv1); end
        nchecks++; if (busy1 !== 1'b0) begin nfails++; $display("[TB] FAIL illegal_busy: got %b expected 0", busy1); end
        nchecks++; if (rk1 !== RK128_10) begin nfails++; $display("[TB] FAIL illegal_rk10: got %h expected %h", rk1, RK128_10); end
        tick();
        nchecks++; if (err1 !== 1'b0) begin nfails++; $display("[TB] FAIL illegal_err_pulse: got %b expected 0", err1); end
        nchecks++; if (busy1 !== 1'b0 || done1 !== 1'b0) begin nfails++; $display("[TB] FAIL illegal_stays_idle: got busy=%b done=%b expected 0 0", busy1, done1); end
    endtask

    task automatic test_aes192();
        int c1, c2, c4;
        start_run(2'b01, KEY192);
        nchecks++; if (kv1 !== 1'b0) begin nfails++; $display("[TB] FAIL aes192_kv_cleared: got %b expected 0", kv1); end
        nchecks++; if (busy1 !== 1'b1) begin nfails++; $display("[TB] FAIL aes192_busy: got %b expected 1", busy1); end
        wait_all(1, 200, c1, c2, c4);
        nchecks++; if (c1 !== 79) begin nfails++; $display("[TB] FAIL aes192_done_l1: got %0d expected 79", c1); end
        nchecks++; if (c2 !== 63) begin nfails++; $display("[TB] FAIL aes192_done_l2: got %0d expected 63", c2); end
        nchecks++; if (c4 !== 55) begin nfails++; $display("[TB] FAIL aes192_done_l4: got %0d expected 55", c4); end
        rk_addr = 4'd12; #1;
        nchecks++; if (rk1 !== RK192_12) begin nfails++; $display("[TB] FAIL aes192_rk12_l1: got %h expected %h", rk1, RK192_12); end
        nchecks++; if (rk2 !== RK192_12) begin nfails++; $display("[TB] FAIL aes192_rk12_l2: got %h expected %h", rk2, RK192_12); end
        nchecks++; if (rk4 !== RK192_12) begin nfails++; $display("[TB] FAIL aes192_rk12_l4: got %h expected %h", rk4, RK192_12); end
        rk_addr = 4'd13; #1;
        nchecks++; if (rk1 !== 128'h0) begin nfails++; $display("[TB] FAIL aes192_rk13_zero: got %h expected 0", rk1); end
        tick();
    endtask

    task automatic test_aes256_lanes();
        int c1, c2, c4;
        start_run(2'b10, KEY256);
        wait_all(1, 200, c1, c2, c4);
        nchecks++; if (c1 !== 105) begin nfails++; $display("[TB] FAIL aes256_done_l1: got %0d expected 105", c1); end
        nchecks++; if (c2 !== 79) begin nfails++; $display("[TB] FAIL aes256_done_l2: got %0d expected 79", c2); end
        nchecks++; if (c4 !== 66) begin nfails++; $display("[TB] FAIL aes256_done_l4: got %0d expected 66", c4); end
        rk_addr = 4'd14; #1;
        nchecks++; if (rk1 !== RK256_14) begin nfails++; $display("[TB] FAIL aes256_rk14_l1: got %h expected %h", rk1, RK256_14); end
        nchecks++; if (rk2 !== RK256_14) begin nfails++; $display("[TB] FAIL aes256_rk14_l2: got %h expected %h", rk2, RK256_14); end
        nchecks++; if (rk4 !== RK256_14) begin nfails++; $display("[TB] FAIL aes256_rk14_l4: got %h expected %h", rk4, RK256_14); end
        rk_addr = 4'd1; #1;
        nchecks++; if (rk1 !== RK256_1) begin nfails++; $display("[TB] FAIL aes256_rk1: got %h expected %h", rk1, RK256_1); end
        rk_addr = 4'd2; #1;
        nchecks++; if (rk1 !== RK256_2) begin nfails++; $display("[TB] FAIL aes256_rk2: got %h expected %h", rk1, RK256_2); end
        tick();
    endtask

    task automatic test_start_while_busy();
        int c1, c2, c4;
        start_run(2'b00, KEY128);
        for (int c = 1; c < 10; c++) tick();
        mode   = 2'b10;
        key_in = KEY256;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        nchecks++; if (busy1 !== 1'b1 || err1 !== 1'b0) begin nfails++; $display("[TB] FAIL busy_start_ignored: got busy=%b err=%b expected 1 0", busy1, err1); end
        wait_all(11, 200, c1, c2, c4);
        nchecks++; if (c1 !== 81) begin nfails++; $display("[TB] FAIL busy_done_l1: got %0d expected 81", c1); end
        nchecks++; if (c4 !== 51) begin nfails++; $display("[TB] FAIL busy_done_l4: got %0d expected 51", c4); end
        rk_addr = 4'd10; #1;
        nchecks++; if (rk1 !== RK128_10) begin nfails++; $display("[TB] FAIL busy_rk10_l1: got %h expected %h", rk1, RK128_10); end
        nchecks++; if (rk4 !== RK128_10) begin nfails++; $display("[TB] FAIL busy_rk10_l4: got %h expected %h", rk4, RK128_10); end
        tick();
    endtask

    task automatic test_reset_abort_restart();
        int c1, c2, c4;
        logic seen;
        start_run(2'b10, KEY256);
        for (int c = 1; c < 30; c++) tick();
        reset_n = 1'b0;
        rk_addr = 4'd14;
        tick();
        nchecks++; if (busy1 !== 1'b0) begin nfails++; $display("[TB] FAIL abort_busy: got %b expected 0", busy1); end
        nchecks++; if (kv1 !== 1'b0) begin nfails++; $display("[TB] FAIL abort_key_valid: got %b expected 0", kv1); end
        nchecks++; if (rk1 !== 128'h0) begin nfails++; $display("[TB] FAIL abort_rk_zero: got %h expected 0", rk1); end
        nchecks++; if (busy2 !== 1'b0 || busy4 !== 1'b0) begin nfails++; $display("[TB] FAIL abort_busy_lanes: got %b %b expected 0 0", busy2, busy4); end
        reset_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (done1 || done2 || done4 || busy1) seen = 1'b1;
        end
        nchecks++; if (seen !== 1'b0) begin nfails++; $display("[TB] FAIL abort_no_done: got %b expected 0", seen); end
        start_run(2'b00, KEY128);
        wait_all(1, 200, c1, c2, c4);
        nchecks++; if (c1 !== 81) begin nfails++; $display("[TB] FAIL restart_done_l1: got %0d expected 81", c1); end
        nchecks++; if (c2 !== 61) begin nfails++; $display("[TB] FAIL restart_done_l2: got %0d expected 61", c2); end
        rk_addr = 4'd10; #1;
        nchecks++; if (rk1 !== RK128_10) begin nfails++; $display("[TB] FAIL restart_rk10: got %h expected %h", rk1, RK128_10); end
        rk_addr = 4'd1; #1;
        nchecks++; if (rk1 !== RK128_1) begin nfails++; $display("[TB] FAIL restart_rk1: got %h expected %h", rk1, RK128_1); end
        tick();
    endtask

    initial begin
        test_reset();
        test_aes128();
        test_illegal_mode();
        test_aes192();
        test_aes256_lanes();
        test_start_while_busy();
        test_reset_abort_restart();
        $display("End of test - %0d assertions evaluated, %0d failures", nchecks, nfails);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
